// File: rtl/i2s_in.sv
// I2S slave receiver: resamples bclk/ws/d onto clk_in and deserialises
// MSB-first slots into parallel words with a channel flag.
//
// Ports:
//   clk_in, reset_in        system clock, async active-high reset
//   bclk_in, ws_in, d_in    raw I2S bit clock, word select, serial data
//   data_out, right_out     last completed word and its channel (1=right)
//   data_valid_out          one-cycle pulse per completed word
//   frame_err_out           one-cycle pulse per short slot
`timescale 1ns/1ps
module i2s_in #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              bclk_in,
  input  logic              ws_in,
  input  logic              d_in,
  output logic [DATA_W-1:0] data_out,
  output logic              right_out,
  output logic              data_valid_out,
  output logic              frame_err_out
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {HUNT, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sy;
  logic [SYNC_STAGES-1:0] ws_sy;
  logic [SYNC_STAGES-1:0] d_sy;
  logic                   bclk_p;
  logic                   rise;

  logic smp_vld;
  logic smp_ws;
  logic smp_d;

  state_t            state;
  logic              ws_q;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] word_q;
  logic              word_right;
  logic              pend_vld;
  logic              pend_err;

  logic              bnd;
  logic [DATA_W-1:0] sh_nx;
  logic [CW-1:0]     cnt_nx;

  assign rise = bclk_sy[SYNC_STAGES-1] & ~bclk_p;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      bclk_sy <= '0;
      ws_sy   <= '0;
      d_sy    <= '0;
      bclk_p  <= 1'b0;
      smp_vld <= 1'b0;
      smp_ws  <= 1'b0;
      smp_d   <= 1'b0;
    end else begin
      bclk_sy <= {bclk_sy[SYNC_STAGES-2:0], bclk_in};
      ws_sy   <= {ws_sy[SYNC_STAGES-2:0], ws_in};
      d_sy    <= {d_sy[SYNC_STAGES-2:0], d_in};
      bclk_p  <= bclk_sy[SYNC_STAGES-1];
      smp_vld <= rise;
      if (rise) begin
        smp_ws <= ws_sy[SYNC_STAGES-1];
        smp_d  <= d_sy[SYNC_STAGES-1];
      end
    end
  end

  // Shift rule shared by normal and boundary rises; bit_cnt
  // saturates so long slots keep only their leading bits.
  always_comb begin
    bnd    = smp_vld && (smp_ws != ws_q);
    sh_nx  = shreg;
    cnt_nx = bit_cnt;
    if (bit_cnt < CW'(DATA_W)) begin
      sh_nx  = {shreg[DATA_W-2:0], smp_d};
      cnt_nx = bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= HUNT;
      ws_q       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_q     <= '0;
      word_right <= 1'b0;
      pend_vld   <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      pend_vld <= 1'b0;
      pend_err <= 1'b0;
      if (smp_vld) begin
        ws_q <= smp_ws;
        unique case (state)
          HUNT: begin
            if (bnd) begin
              state   <= SHIFT;
              shreg   <= '0;
              bit_cnt <= '0;
            end
          end
          SHIFT: begin
            if (!bnd) begin
              shreg   <= sh_nx;
              bit_cnt <= cnt_nx;
            end else begin
              // d at the boundary rise is the LSB of the closing slot
              if (cnt_nx == CW'(DATA_W)) begin
                word_q     <= sh_nx;
                word_right <= ws_q;
                pend_vld   <= 1'b1;
              end else begin
                pend_err <= 1'b1;
              end
              shreg   <= '0;
              bit_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      data_out       <= '0;
      right_out      <= 1'b0;
      data_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      data_valid_out <= pend_vld;
      frame_err_out  <= pend_err;
      if (pend_vld) begin
        data_out  <= word_q;
        right_out <= word_right;
      end
    end
  end

endmodule

// File: tb/tb_i2s_in.sv
// Bench for i2s_in: slot-level reference model, two DUTs
// (SYNC_STAGES 2 and 3) fed the same I2S stream.
`timescale 1ns/1ps
module tb_i2s_in;

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
    logic        right;
  } ev_t;

  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic bclk_in = 1'b0;
  logic ws_in = 1'b0;
  logic d_in = 1'b0;

  logic [15:0] dout [2];
  logic        rgt  [2];
  logic        vld  [2];
  logic        err  [2];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int bnd_cyc = 0;
  int pulses = 0;

  ev_t q0[$];
  ev_t q1[$];
  logic [15:0] last_exp [2];

  int          slen[$];
  logic [31:0] sval[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_in #(.DATA_W(16), .SYNC_STAGES(2)) u0 (
    .clk_in(clk), .reset_in(reset_in),
    .bclk_in(bclk_in), .ws_in(ws_in), .d_in(d_in),
    .data_out(dout[0]), .right_out(rgt[0]),
    .data_valid_out(vld[0]), .frame_err_out(err[0])
  );

  i2s_in #(.DATA_W(16), .SYNC_STAGES(3)) u1 (
    .clk_in(clk), .reset_in(reset_in),
    .bclk_in(bclk_in), .ws_in(ws_in), .d_in(d_in),
    .data_out(dout[1]), .right_out(rgt[1]),
    .data_valid_out(vld[1]), .frame_err_out(err[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    logic have;
    if (reset_in) begin
      last_exp[0] = '0;
      last_exp[1] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      if (vld[i] || err[i]) begin
        pulses++;
        have = 1'b0;
        e = '0;
        if (i == 0 && q0.size() > 0) begin
          e = q0.pop_front();
          have = 1'b1;
        end
        if (i == 1 && q1.size() > 0) begin
          e = q1.pop_front();
          have = 1'b1;
        end
        chk("excl", {31'b0, vld[i] & err[i]}, 0);
        chk("expected", {31'b0, have}, 1);
        if (have) begin
          chk("kind", {31'b0, err[i]}, {31'b0, e.is_err});
          chk("lat", cyc - bnd_cyc, (i == 0) ? 4 : 5);
          if (!e.is_err) begin
            chk("data", {16'b0, dout[i]}, {16'b0, e.data});
            chk("right", {31'b0, rgt[i]}, {31'b0, e.right});
            last_exp[i] = e.data;
          end else begin
            chk("hold", {16'b0, dout[i]},
                {16'b0, last_exp[i]});
          end
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_data"}, {16'b0, dout[i]}, 0);
      chk({tag, "_right"}, {31'b0, rgt[i]}, 0);
      chk({tag, "_vld"}, {31'b0, vld[i]}, 0);
      chk({tag, "_err"}, {31'b0, err[i]}, 0);
    end
  endtask

  // Drives slots slen/sval (ws alternates from 0) and optionally
  // pulses reset halfway through slot rslot (must be a left slot).
  task automatic run(input int rslot);
    logic ws_p[$];
    logic d_p[$];
    logic bits[$];
    int   st[$];
    int   r;
    int   n;
    ev_t  e;
    n = slen.size();
    reset_in = 1'b1;
    bclk_in = 1'b0;
    ws_in = 1'b0;
    d_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    #2 reset_in = 1'b0;
    for (int k = 0; k < n; k++) begin
      st.push_back(ws_p.size());
      for (int i = 0; i < slen[k]; i++) begin
        ws_p.push_back(k[0]);
        bits.push_back(sval[k][slen[k]-1-i]);
      end
    end
    d_p.push_back(1'b0);
    for (int i = 0; i < bits.size() - 1; i++)
      d_p.push_back(bits[i]);
    r = -1;
    if (rslot >= 0) r = st[rslot] + slen[rslot] / 2;
    for (int k = 1; k < n - 1; k++) begin
      if (r < 0 || ((st[k] >= r) == (st[k+1] >= r))) begin
        e.is_err = (slen[k] < 16);
        e.data = 16'(sval[k] >> (slen[k] - 16));
        if (slen[k] < 16) e.data = '0;
        e.right = k[0];
        q0.push_back(e);
        q1.push_back(e);
      end
    end
    for (int p = 0; p < ws_p.size(); p++) begin
      @(negedge clk);
      bclk_in = 1'b0;
      ws_in = ws_p[p];
      d_in = d_p[p];
      if (p == r) begin
        #2 reset_in = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk);
        #2 reset_in = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (3) @(negedge clk);
      end
      @(negedge clk);
      bclk_in = 1'b1;
      if (p > 0 && ws_p[p] != ws_p[p-1]) bnd_cyc = cyc + 1;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    bclk_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    slen.delete();
    sval.delete();
  endtask

  task automatic add(input int l, input logic [31:0] v);
    slen.push_back(l);
    sval.push_back(v);
  endtask

  initial begin
    int lt[6];
    int p0;
    lt = '{8, 12, 16, 17, 24, 32};

    // loopback: left AA00 then right 5555
    add(16, 32'h0000_F0F0);
    add(16, 32'h0000_1111);
    add(16, 32'h0000_AA00);
    add(16, 32'h0000_5555);
    add(16, 32'h0000_0F0F);
    add(16, 32'h0000_0000);
    run(-1);

    // 32-bit slots: 1234 then sixteen ones
    for (int k = 0; k < 5; k++) add(32, 32'h1234_FFFF);
    run(-1);

    // short slot after a good word
    add(16, 32'h0000_0001);
    add(16, 32'h0000_BEEF);
    add(8, 32'h0000_005A);
    add(16, 32'h0000_C0DE);
    add(16, 32'h0000_0000);
    run(-1);

    // reset pulse mid left word
    add(16, 32'h0000_0000);
    add(16, 32'h0000_A5A5);
    add(16, 32'h0000_7E57);
    add(16, 32'h0000_1357);
    add(16, 32'h0000_2468);
    add(16, 32'h0000_9999);
    run(2);

    // randomized slots
    for (int t = 0; t < 6; t++) begin
      add(16, $urandom);
      for (int k = 1; k < 10; k++)
        add(lt[$urandom_range(0, 5)], $urandom);
      run((t % 2 == 1) ? 2 * $urandom_range(1, 3) : -1);
    end

    // ws activity with bclk idle
    p0 = pulses;
    for (int k = 0; k < 6; k++) begin
      ws_in = ~ws_in;
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("ws_idle", pulses - p0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
